// File: rtl/reg_bank_pkg.sv
//----------------------------------------------------------------------------
// reg_bank_pkg
// Shared types and helpers for reg_bank_arbiter and rr_pick.
//   state_t : arbiter FSM state (IDLE -> OWN -> GAP -> IDLE), 2 bits
//   clog2   : constant-foldable ceiling log2, used for address/index widths
// No ports (package).
//----------------------------------------------------------------------------
package reg_bank_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Ceiling log2 with a floor of 1 so index vectors never collapse to zero width.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
//----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: returns the first eligible requester
// at or after the pointer, wrapping from NREQ-1 back to 0.
// Ports:
//   i_req   [NREQ-1:0]  request vector
//   i_mask  [NREQ-1:0]  requesters excluded from this pick (1 = excluded)
//   i_ptr   [OW-1:0]    index with highest priority
//   o_pick  [NREQ-1:0]  one-hot selected requester (zero when none)
//   o_idx   [OW-1:0]    binary index of the selected requester
//   o_valid             at least one eligible requester
//----------------------------------------------------------------------------
module rr_pick
    import reg_bank_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int OW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [NREQ-1:0] i_mask,
    input  logic [OW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_pick,
    output logic [OW-1:0]   o_idx,
    output logic            o_valid
);

    logic [NREQ-1:0] w_elig;

    assign w_elig = i_req & ~i_mask;

    // Walk from the farthest offset back to offset 0 so the candidate nearest
    // the pointer is the last one written and therefore wins.
    always_comb begin
        o_pick  = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(i_ptr) + k) % NREQ;
            if (w_elig[idx]) begin
                o_pick      = '0;
                o_pick[idx] = 1'b1;
                o_idx       = OW'(idx);
                o_valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
//----------------------------------------------------------------------------
// reg_bank_arbiter
// One bank of DEPTH x WIDTH registers shared by NREQ requesters. A round-robin
// req/gnt handshake decides the single owner; only the owner's writes land in
// the bank. The read port is common and combinational.
//
// Handshake: a requester raises req[i] and holds it; gnt[i] rises the cycle
// after the pick and stays high while req[i] stays high. Dropping req[i]
// releases ownership (gnt falls next cycle), followed by a one-cycle GAP.
// A write is taken at any edge where gnt[owner]=1 and wr_en[owner]=1.
//
// Ports:
//   clk      clock, all state on posedge
//   res      synchronous active-high reset
//   req      [NREQ]        request/hold per requester
//   wr_en    [NREQ]        write strobe per requester
//   wr_addr  [NREQ*AW]     requester i at [i*AW +: AW]
//   wr_data  [NREQ*WIDTH]  requester i at [i*WIDTH +: WIDTH]
//   rd_addr  [AW]          common read address
//   gnt      [NREQ]        one-hot grant, zero when idle
//   rd_data  [WIDTH]       bank[rd_addr]
//   wr_drop                one-cycle pulse: a non-owner write was ignored
//
// Build option: define ARB_TIMEOUT_EN to limit ownership to MAX_HOLD cycles;
// a revoked requester is skipped until it drops req for at least one cycle.
//----------------------------------------------------------------------------
module reg_bank_arbiter
    import reg_bank_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int MAX_HOLD = 8,
    localparam int AW      = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       wr_en,
    input  logic [NREQ*AW-1:0]    wr_addr,
    input  logic [NREQ*WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  wr_drop
);

    localparam int OW = clog2(NREQ);

    state_t           r_state;
    logic [NREQ-1:0]  r_gnt;
    logic [OW-1:0]    r_owner;
    logic [OW-1:0]    r_ptr;
    logic             r_drop;
    logic [WIDTH-1:0] r_bank [DEPTH];

    logic [NREQ-1:0]  w_pick;
    logic [OW-1:0]    w_pick_idx;
    logic             w_pick_valid;
    logic [NREQ-1:0]  w_mask;
    logic             w_expire;
    logic             w_own_req;
    logic             w_own_wr;
    logic [AW-1:0]    w_wr_addr;
    logic [WIDTH-1:0] w_wr_data;
    logic [OW-1:0]    w_next_ptr;

    assign w_own_req  = req[r_owner];
    assign w_own_wr   = (r_state == OWN) && wr_en[r_owner];
    assign w_wr_addr  = wr_addr[r_owner*AW +: AW];
    assign w_wr_data  = wr_data[r_owner*WIDTH +: WIDTH];
    assign w_next_ptr = (r_owner == OW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .i_req   (req),
        .i_mask  (w_mask),
        .i_ptr   (r_ptr),
        .o_pick  (w_pick),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int HW = clog2(MAX_HOLD) + 1;

    logic [HW-1:0]   r_hold;
    logic [NREQ-1:0] r_mask;
    logic [NREQ-1:0] w_mask_set;

    // r_hold counts completed OWN cycles, so the MAX_HOLD-th owned cycle is the last.
    assign w_expire   = (r_state == OWN) && (r_hold == HW'(MAX_HOLD - 1));
    assign w_mask     = r_mask;
    assign w_mask_set = (w_expire && w_own_req) ? r_gnt : '0;

    always_ff @(posedge clk) begin
        if (res) begin
            r_hold <= '0;
            r_mask <= '0;
        end else begin
            if (r_state == OWN) begin
                r_hold <= r_hold + 1'b1;
            end else begin
                r_hold <= '0;
            end
            // A revoked requester regains eligibility once it has released req.
            r_mask <= (r_mask & req) | w_mask_set;
        end
    end
`else
    assign w_expire = 1'b0;
    assign w_mask   = '0;
`endif

    // Arbitration FSM with registered grant.
    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_gnt   <= w_pick;
                        r_owner <= w_pick_idx;
                        r_state <= OWN;
                    end
                end
                OWN: begin
                    if (!w_own_req || w_expire) begin
                        r_gnt   <= '0;
                        r_state <= GAP;
                    end
                end
                GAP: begin
                    r_ptr   <= w_next_ptr;
                    r_state <= IDLE;
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Any write strobe from a requester not currently granted is reported.
    always_ff @(posedge clk) begin
        if (res) begin
            r_drop <= 1'b0;
        end else begin
            r_drop <= |(wr_en & ~r_gnt);
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_bank[i] <= '0;
            end
        end else if (w_own_wr) begin
            r_bank[w_wr_addr] <= w_wr_data;
        end
    end

    assign gnt     = r_gnt;
    assign wr_drop = r_drop;
    assign rd_data = r_bank[rd_addr];

endmodule
